// File: rtl/aes_out_fifo_4to1_if.sv
// aes_out_fifo_4to1_if: result-capture and word-read bundle for the AES output FIFO
interface aes_out_fifo_4to1_if #(parameter int LVL_W = 4);
  logic [127:0]     inp_fifo;
  logic             wr_fifo;
  logic             rd_word;
  logic             clr_err;
  logic [31:0]      outp_word;
  logic [1:0]       word_idx;
  logic             fifo_empty;
  logic             fifo_full;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             underflow;
  modport slave (
    input  inp_fifo, wr_fifo, rd_word, clr_err,
    output outp_word, word_idx, fifo_empty, fifo_full, level, overflow, underflow
  );
  modport master (
    output inp_fifo, wr_fifo, rd_word, clr_err,
    input  outp_word, word_idx, fifo_empty, fifo_full, level, overflow, underflow
  );
endinterface

// File: rtl/aes_out_fifo_4to1.sv
// aes_out_fifo_4to1: circular buffer of 128-bit AES results read out as four 32-bit words
module aes_out_fifo_4to1 #(
  parameter int DEPTH = 10,
  parameter int LVL_W = 4
) (
  input logic                 S_AXI_ACLK,
  input logic                 S_AXI_ARESETN,
  aes_out_fifo_4to1_if.slave  bus
);
  typedef enum logic [1:0] {W0, W1, W2, W3} state_t;
  state_t           r_state, w_next;
  logic [127:0]     r_mem [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic             r_ovf, r_unf;
  logic             w_empty, w_full, w_rd, w_pop, w_wr;
  logic [127:0]     w_head;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == LVL_W'(DEPTH);
  assign w_rd    = bus.rd_word & !w_empty;
  assign w_pop   = w_rd & (r_state == W3);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the write
  assign w_wr    = bus.wr_fifo & (!w_full | w_pop);
  assign w_head  = r_mem[r_rd_ptr];
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) r_state <= W0;
    else r_state <= w_next;
  always_comb w_next = w_rd ? state_t'(r_state + 2'd1) : r_state;
  always_comb begin
    bus.word_idx  = r_state;
    bus.outp_word = w_empty ? 32'd0 : w_head[{~r_state, 5'd0} +: 32];
  end
  always_ff @(posedge S_AXI_ACLK)
    if (w_wr) r_mem[r_wr_ptr] <= bus.inp_fifo;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= (r_wr_ptr == LVL_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LVL_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + LVL_W'(w_wr & !w_pop) - LVL_W'(w_pop & !w_wr);
      r_ovf   <= (bus.wr_fifo & !w_wr) | (r_ovf & !bus.clr_err);
      r_unf   <= (bus.rd_word & w_empty) | (r_unf & !bus.clr_err);
    end
  assign bus.fifo_empty = w_empty;
  assign bus.fifo_full  = w_full;
  assign bus.level      = r_count;
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_unf;
endmodule
